// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte producers.
// Optional packet lock (ReqLast-delimited) enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [NREQ-1:0]     ReqValid,
    input  logic [8*NREQ-1:0]   ReqData,
    input  logic [NREQ-1:0]     ReqLast,
    output logic [NREQ-1:0]     ReqReady,
    output logic [7:0]          TxData,
    output logic                TxEn,
    input  logic                TxDone,
    output logic [NREQ-1:0]     Grant,
    output logic                Busy,
    output logic                Timeout
);

    localparam int          IW       = $clog2(NREQ);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [15:0]     cnt;
    logic            lock_held;
    logic [NREQ-1:0] eligible;
    logic            found;
    logic [IW-1:0]   pick;
    logic [NREQ-1:0] pick_oh;
    logic            done;
    logic            expired;
    logic [7:0]      req_bytes [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_bytes
        assign req_bytes[g] = ReqData[8*g +: 8];
    end

`ifdef UART_ARB_LOCK_EN
    logic owner_last;
    // While locked, Grant still holds the owner's one-hot, so it doubles as the eligibility mask.
    assign eligible = lock_held ? (ReqValid & Grant) : ReqValid;
`else
    logic unused_last;
    assign unused_last = ^ReqLast;
    assign eligible    = ReqValid;
`endif

    // Search starts just above the last served requester and wraps.
    always_comb begin
        logic [IW-1:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign pick_oh = {{(NREQ-1){1'b0}}, 1'b1} << pick;
    // TxEn is still high on the first WAIT edge; a TxDone there belongs to an older frame.
    assign done    = TxDone && !TxEn;
    assign expired = (cnt == CNT_LAST);
    assign Busy    = (state == WAIT) | lock_held;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            ptr        <= IW'(NREQ - 1);
            owner      <= '0;
            cnt        <= '0;
            lock_held  <= 1'b0;
            ReqReady   <= '0;
            TxData     <= 8'h00;
            TxEn       <= 1'b0;
            Grant      <= '0;
            Timeout    <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            owner_last <= 1'b0;
`endif
        end else begin
            // NOTE: pulse outputs default low every edge and are raised only on the edge that needs them.
            ReqReady <= '0;
            TxEn     <= 1'b0;
            Timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        TxData   <= req_bytes[pick];
                        Grant    <= pick_oh;
                        ReqReady <= pick_oh;
                        TxEn     <= 1'b1;
                        cnt      <= '0;
                        owner    <= pick;
                        state    <= WAIT;
`ifdef UART_ARB_LOCK_EN
                        owner_last <= ReqLast[pick];
                        if (!ReqLast[pick]) lock_held <= 1'b1;
`endif
                    end
                end
                WAIT: begin
                    if (done || expired) begin
                        Timeout <= !done;
                        ptr     <= owner;
                        state   <= IDLE;
`ifdef UART_ARB_LOCK_EN
                        if (owner_last) begin
                            Grant     <= '0;
                            lock_held <= 1'b0;
                        end
`else
                        Grant   <= '0;
`endif
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
